// File: rtl/isa_pkg.sv
// ISA constants, decode-state enum, control/bundle structs and the
// combinational opcode decode table shared by the decode stage.
package isa_pkg;

   localparam int DATA_W = 16;
   localparam int NREGS  = 8;
   localparam int AW     = $clog2(NREGS);

   localparam logic [5:0] OP_ADD = 6'b000011;
   localparam logic [5:0] OP_NOT = 6'b000100;
   localparam logic [5:0] OP_NOP = 6'b000101;
   localparam logic [5:0] OP_LDM = 6'b010001;
   localparam logic [5:0] OP_STD = 6'b010010;
   localparam logic [5:0] OP_LDD = 6'b010011;

   typedef enum logic {
      S_OP  = 1'b0,
      S_IMM = 1'b1
   } state_t;

   typedef struct packed {
      logic reg_we;
      logic mem_rd;
      logic mem_wr;
      logic use_imm;
      logic illegal;
   } ctrl_t;

   typedef struct packed {
      logic [5:0]        opcode;
      logic [AW-1:0]     src;
      logic [AW-1:0]     dst;
      logic [3:0]        shamt;
      logic [DATA_W-1:0] rs_data;
      logic [DATA_W-1:0] rd_data;
      logic [DATA_W-1:0] imm;
      ctrl_t             ctrl;
   } id_ex_t;

   function automatic ctrl_t decode(input logic [5:0] op);
      ctrl_t c;
      c = '0;
      case (op)
         OP_ADD: c.reg_we = 1'b1;
         OP_NOT: c.reg_we = 1'b1;
         OP_NOP: c = '0;
         OP_LDM: begin
            c.reg_we  = 1'b1;
            c.use_imm = 1'b1;
         end
         OP_STD: c.mem_wr = 1'b1;
         OP_LDD: begin
            c.mem_rd = 1'b1;
            c.reg_we = 1'b1;
         end
         default: c.illegal = 1'b1;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/reg_file.sv
// 8x16 register file: two async read ports, one sync write port,
// synchronous active-low clear.
module reg_file
   import isa_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [AW-1:0]     raddr_a,
   input  logic [AW-1:0]     raddr_b,
   output logic [DATA_W-1:0] rdata_a,
   output logic [DATA_W-1:0] rdata_b
);

   logic [DATA_W-1:0] mem [NREGS];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) mem[i] <= '0;
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata_a = mem[raddr_a];
   assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/decode_stage.sv
// Decode stage: LDM two-word assembly, regfile read, ID/EX bundle.
// Optional DECODE_WB_BYPASS_EN forwards same-cycle write-back into capture.
module decode_stage
   import isa_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_valid,
   input  logic [5:0]        if_opcode,
   input  logic [AW-1:0]     if_src,
   input  logic [AW-1:0]     if_dst,
   input  logic [3:0]        if_shamt,
   input  logic [DATA_W-1:0] if_word,
   output logic              id_ready,
   input  logic              flush,
   input  logic              ex_ready,
   output logic              id_valid,
   output logic [5:0]        id_opcode,
   output logic [AW-1:0]     id_src,
   output logic [AW-1:0]     id_dst,
   output logic [3:0]        id_shamt,
   output logic [DATA_W-1:0] id_rs_data,
   output logic [DATA_W-1:0] id_rd_data,
   output logic [DATA_W-1:0] id_imm,
   output logic              id_reg_we,
   output logic              id_mem_rd,
   output logic              id_mem_wr,
   output logic              id_use_imm,
   output logic              id_illegal,
   input  logic              wb_we,
   input  logic [AW-1:0]     wb_addr,
   input  logic [DATA_W-1:0] wb_data
);

   state_t            state_q, state_d;
   id_ex_t            bund_q, bund_d, pend_q, cap;
   logic              valid_q, accept, load, hold_pend;
   logic [DATA_W-1:0] rf_a, rf_b, rs_cap, rd_cap;

   reg_file u_rf (
      .clk     (clk),
      .rst_n   (rst_n),
      .we      (wb_we),
      .waddr   (wb_addr),
      .wdata   (wb_data),
      .raddr_a (if_src),
      .raddr_b (if_dst),
      .rdata_a (rf_a),
      .rdata_b (rf_b)
   );

`ifdef DECODE_WB_BYPASS_EN
   assign rs_cap = (wb_we && wb_addr == if_src) ? wb_data : rf_a;
   assign rd_cap = (wb_we && wb_addr == if_dst) ? wb_data : rf_b;
`else
   assign rs_cap = rf_a;
   assign rd_cap = rf_b;
`endif

   assign id_ready = rst_n && (!valid_q || ex_ready);
   assign accept   = if_valid && id_ready;

   always_comb begin
      cap         = '0;
      cap.opcode  = if_opcode;
      cap.src     = if_src;
      cap.dst     = if_dst;
      cap.shamt   = if_shamt;
      cap.rs_data = rs_cap;
      cap.rd_data = rd_cap;
      cap.ctrl    = decode(if_opcode);
   end

   always_comb begin
      state_d   = state_q;
      bund_d    = cap;
      load      = 1'b0;
      hold_pend = 1'b0;
      if (flush) begin
         state_d = S_OP;
      end else if (accept) begin
         unique case (state_q)
            S_OP: begin
               if (if_opcode == OP_LDM) begin
                  state_d   = S_IMM;
                  hold_pend = 1'b1;
               end else begin
                  load = 1'b1;
               end
            end
            S_IMM: begin
               state_d    = S_OP;
               bund_d     = pend_q;
               bund_d.imm = if_word;
               load       = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= S_OP;
      else        state_q <= state_d;
   end

   // flush beats retire/load because load is already gated by flush
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         bund_q  <= '0;
         pend_q  <= '0;
      end else begin
         if (flush || (valid_q && ex_ready)) valid_q <= 1'b0;
         if (load) begin
            bund_q  <= bund_d;
            valid_q <= 1'b1;
         end
         if (hold_pend) pend_q <= cap;
      end
   end

   assign id_valid   = valid_q;
   assign id_opcode  = bund_q.opcode;
   assign id_src     = bund_q.src;
   assign id_dst     = bund_q.dst;
   assign id_shamt   = bund_q.shamt;
   assign id_rs_data = bund_q.rs_data;
   assign id_rd_data = bund_q.rd_data;
   assign id_imm     = bund_q.imm;
   assign id_reg_we  = bund_q.ctrl.reg_we;
   assign id_mem_rd  = bund_q.ctrl.mem_rd;
   assign id_mem_wr  = bund_q.ctrl.mem_wr;
   assign id_use_imm = bund_q.ctrl.use_imm;
   assign id_illegal = bund_q.ctrl.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed scenarios plus random traffic
// against an instruction-level reference model.
module tb_decode_stage;

   typedef struct packed {
      logic [5:0]  op;
      logic [2:0]  src;
      logic [2:0]  dst;
      logic [3:0]  sh;
      logic [15:0] rs;
      logic [15:0] rd;
      logic [15:0] imm;
      logic [4:0]  ctl;
   } exp_t;

   logic        clk = 0;
   logic        rst_n = 0;
   logic        if_valid = 0;
   logic [5:0]  if_opcode = 0;
   logic [2:0]  if_src = 0, if_dst = 0;
   logic [3:0]  if_shamt = 0;
   logic [15:0] if_word = 0;
   logic        id_ready;
   logic        flush = 0;
   logic        ex_ready = 0;
   logic        id_valid;
   logic [5:0]  id_opcode;
   logic [2:0]  id_src, id_dst;
   logic [3:0]  id_shamt;
   logic [15:0] id_rs_data, id_rd_data, id_imm;
   logic        id_reg_we, id_mem_rd, id_mem_wr, id_use_imm, id_illegal;
   logic        wb_we = 0;
   logic [2:0]  wb_addr = 0;
   logic [15:0] wb_data = 0;

   int          total = 0;
   int          bad = 0;
   exp_t        q[$];
   logic [15:0] regs [8];
   bit          pend = 0;
   exp_t        pend_b;
   exp_t        act;

   decode_stage dut (
      .clk(clk), .rst_n(rst_n), .if_valid(if_valid),
      .if_opcode(if_opcode), .if_src(if_src), .if_dst(if_dst),
      .if_shamt(if_shamt), .if_word(if_word), .id_ready(id_ready),
      .flush(flush), .ex_ready(ex_ready), .id_valid(id_valid),
      .id_opcode(id_opcode), .id_src(id_src), .id_dst(id_dst),
      .id_shamt(id_shamt), .id_rs_data(id_rs_data),
      .id_rd_data(id_rd_data), .id_imm(id_imm),
      .id_reg_we(id_reg_we), .id_mem_rd(id_mem_rd),
      .id_mem_wr(id_mem_wr), .id_use_imm(id_use_imm),
      .id_illegal(id_illegal), .wb_we(wb_we), .wb_addr(wb_addr),
      .wb_data(wb_data)
   );

   always #5 clk = ~clk;

   assign act = {id_opcode, id_src, id_dst, id_shamt, id_rs_data,
                 id_rd_data, id_imm, id_reg_we, id_mem_rd, id_mem_wr,
                 id_use_imm, id_illegal};

   // {reg_we, mem_rd, mem_wr, use_imm, illegal} from the opcode table
   function automatic logic [4:0] ctl(input logic [5:0] op);
      case (op)
         6'd3:    return 5'b10000;
         6'd4:    return 5'b10000;
         6'd5:    return 5'b00000;
         6'd17:   return 5'b10010;
         6'd18:   return 5'b00100;
         6'd19:   return 5'b11000;
         default: return 5'b00001;
      endcase
   endfunction

   task automatic step(input logic v, input logic [15:0] w,
                       input logic exr = 1, input logic fl = 0,
                       input logic we = 0, input logic [2:0] wa = 0,
                       input logic [15:0] wd = 0, input logic rs = 1);
      exp_t        e;
      logic        ev, er;
      logic [15:0] a, b;
      @(posedge clk);
      #1;
      if_valid = v;
      if_word  = w;
      {if_opcode, if_src, if_dst, if_shamt} = w;
      ex_ready = exr;
      flush    = fl;
      wb_we    = we;
      wb_addr  = wa;
      wb_data  = wd;
      rst_n    = rs;
      #1;
      ev = q.size() > 0;
      er = rs && (!ev || exr);
      total++;
      if (id_ready !== er) begin
         bad++;
         $display("FAIL id_ready t=%0t: got %b want %b", $time, id_ready, er);
      end
      a = regs[w[9:7]];
      b = regs[w[6:4]];
`ifdef DECODE_WB_BYPASS_EN
      if (we && wa == w[9:7]) a = wd;
      if (we && wa == w[6:4]) b = wd;
`endif
      if (!rs) begin
         q.delete();
         pend = 0;
         foreach (regs[i]) regs[i] = 16'h0;
      end else begin
         if (fl) begin
            q.delete();
            pend = 0;
         end else if (v && er) begin
            if (pend) begin
               e = pend_b;
               e.imm = w;
               q.push_back(e);
               pend = 0;
            end else begin
               e.op  = w[15:10];
               e.src = w[9:7];
               e.dst = w[6:4];
               e.sh  = w[3:0];
               e.rs  = a;
               e.rd  = b;
               e.imm = 16'h0;
               e.ctl = ctl(w[15:10]);
               if (w[15:10] == 6'd17) begin
                  pend   = 1;
                  pend_b = e;
               end else begin
                  q.push_back(e);
               end
            end
         end
         if (we) regs[wa] = wd;
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && id_valid && !flush) begin
         total++;
         if (q.size() == 0) begin
            bad++;
            $display("FAIL bundle t=%0t: got unexpected %h want none",
                     $time, act);
         end else begin
            if (act !== q[0]) begin
               bad++;
               $display("FAIL bundle t=%0t: got %h want %h",
                        $time, act, q[0]);
            end
            if (ex_ready) void'(q.pop_front());
         end
      end
   end

   function automatic logic [15:0] iw(input logic [5:0] op,
                                      input logic [2:0] s,
                                      input logic [2:0] d);
      return {op, s, d, 4'h5};
   endfunction

   initial begin
      logic [5:0]  op;
      logic [15:0] w;
      foreach (regs[i]) regs[i] = 16'h0;
      step(0, 0, 1, 0, 0, 0, 0, 0);
      step(0, 0, 1, 0, 0, 0, 0, 0);
      @(negedge clk);
      total++;
      if ({id_valid, id_ready, act} !== '0) begin
         bad++;
         $display("FAIL reset: got %b %b %h want all zero",
                  id_valid, id_ready, act);
      end
      step(0, 0, 1, 0, 1, 3'd1, 16'h0FFF);
      step(0, 0, 1, 0, 1, 3'd2, 16'h0F0F);
      step(1, iw(6'd3, 3'd2, 3'd1));
      step(0, 0);
      step(1, iw(6'd17, 3'd0, 3'd1));
      step(1, 16'h1234);
      step(0, 0);
      step(1, iw(6'd19, 3'd1, 3'd2));
      for (int i = 0; i < 3; i++) step(1, iw(6'd4, 3'd2, 3'd2), 0);
      step(1, iw(6'd4, 3'd2, 3'd2), 1);
      step(0, 0);
      step(1, iw(6'd17, 3'd2, 3'd1));
      step(0, 0, 1, 1);
      step(1, iw(6'd18, 3'd1, 3'd2));
      step(1, iw(6'd3, 3'd1, 3'd1), 1, 1);
      step(1, iw(6'h3f, 3'd1, 3'd2));
      step(1, iw(6'd4, 3'd0, 3'd3), 1, 0, 1, 3'd3, 16'hABCD);
      step(1, iw(6'd4, 3'd0, 3'd3));
      step(1, iw(6'd17, 3'd0, 3'd1));
      step(0, 0, 1, 0, 0, 0, 0, 0);
      step(1, 16'h1234);
      step(0, 0);
      for (int i = 0; i < 2000; i++) begin
         case ($urandom_range(0, 7))
            0: op = 6'd3;
            1: op = 6'd4;
            2: op = 6'd5;
            3: op = 6'd17;
            4: op = 6'd18;
            5: op = 6'd19;
            6: op = 6'd17;
            default: op = 6'($urandom);
         endcase
         w = {op, 10'($urandom)};
         step($urandom_range(0, 9) < 7, w, $urandom_range(0, 3) != 0,
              $urandom_range(0, 29) == 0, $urandom_range(0, 9) < 4,
              3'($urandom), 16'($urandom), $urandom_range(0, 199) != 0);
      end
      for (int i = 0; i < 4; i++) step(0, 0);
      @(negedge clk);
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d pending want 0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
